// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC and keeps at most one request
// outstanding to instruction memory. It registers the returned word and
// offers it to decode. Execute can redirect the PC, and halt freezes
// fetch once nothing is in flight.
module ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory request
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  // instruction memory response
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  // decode side
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  // control
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic [31:0]     fetch_cnt
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic            halt_pend, halt_pend_n;
  logic            halt_eff;
  logic            req_fire;
  logic            deliver;
  logic            load_inst;

  // Outputs are decoded from state or taken straight from registers.
  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_HOLD);
  assign halted         = (state == S_HALT);
  assign imem_req_addr  = pc;

  assign halt_eff = halt | halt_pend;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign deliver  = inst_valid & inst_ready;

  // Next-state, next-PC and drop/halt bookkeeping.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_n      = drop;
    halt_pend_n = halt_pend | halt;
    load_inst   = 1'b0;

    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end
        if (req_fire) begin
          // A redirect in the same cycle as the fire leaves the issued
          // request in flight for the old PC, so its response is dropped.
          state_n = S_WAIT;
          drop_n  = redirect_valid;
        end else if (halt_eff) begin
          state_n = S_HALT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end
        if (imem_rsp_valid) begin
          drop_n = 1'b0;
          if (halt_eff) begin
            state_n = S_HALT;
          end else if (drop || redirect_valid) begin
            state_n = S_REQ;
          end else begin
            load_inst = 1'b1;
            state_n   = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_n = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end else if (inst_ready) begin
          pc_n = pc + XLEN'(4);
        end
        if (inst_ready && halt_eff) begin
          state_n = S_HALT;
        end else if (inst_ready || redirect_valid) begin
          state_n = S_REQ;
        end
      end

      default: begin
        // HALT is terminal until reset; redirect and responses are ignored.
        state_n     = S_HALT;
        drop_n      = 1'b0;
        halt_pend_n = 1'b0;
      end
    endcase

    if (state_n == S_HALT) begin
      halt_pend_n = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop      <= drop_n;
      halt_pend <= halt_pend_n;
    end
  end

  // Instruction register; only written when a kept response arrives, so it
  // stays stable for the whole time the word is offered to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst    <= '0;
      inst_pc <= '0;
    end else if (load_inst) begin
      inst    <= imem_rsp_data;
      inst_pc <= pc;
    end
  end

  // Delivered-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (deliver) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule
